// File: rtl/btn_pkg.sv
// Shared definitions for the button event path.
//   - State encoding for button_event_fsm (IDLE / HELD / LONG).
//   - min_cnt_w(): smallest timer width able to hold max(long, repeat) - 1.
package btn_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HELD = ST_HELD,
    S_LONG = ST_LONG
  } btn_state_e;

  // The timer only ever counts up to max-1, so $clog2(max) bits are enough.
  // The result is never less than 1 bit.
  function automatic int min_cnt_w(input int long_time, input int repeat_time);
    int mx;
    mx = (long_time > repeat_time) ? long_time : repeat_time;
    return (mx <= 2) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising/falling edge detector for a level that is already synchronous to clk.
// Ports:
//   clk    in   clock, posedge
//   reset  in   asynchronous, active-high; clears the history register
//   d      in   synchronous level
//   rise   out  d & ~d_q  (combinational)
//   fall   out  ~d & d_q  (combinational)
// After reset the history register is 0. A level that is already high
// therefore shows up as one rise on the first clock edge.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/button_event_fsm.sv
// Converts the debounced switch level into single-cycle events.
// The events are press, release, long-press and auto-repeat while held.
// A wrapping press counter is also kept here.
// Ports:
//   clk            in   system clock, posedge
//   reset          in   asynchronous, active-high
//   sw_db          in   debounced switch level, synchronous to clk
//   clear_count    in   synchronous clear of press_count
//   press_pulse    out  1-cycle pulse after a 0->1 of sw_db
//   release_pulse  out  1-cycle pulse after a 1->0 of sw_db
//   long_pulse     out  1-cycle pulse once held for LONG_TIME cycles
//   repeat_pulse   out  1-cycle pulse every REPEAT_TIME cycles after long_pulse
//   held           out  high while the button is considered pressed
//   press_count    out  number of presses, wraps
// All outputs are registered.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | button released, waiting for a rise
// HELD   | pressed, timing toward long_pulse
// LONG   | long-press reached, emitting repeat_pulse every REPEAT_TIME
module button_event_fsm
  import btn_pkg::*;
#(
  parameter int LONG_TIME   = 50_000_000,
  parameter int REPEAT_TIME = 10_000_000,
  parameter int CNT_W       = 27,
  parameter int PCNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_db,
  input  logic              clear_count,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              long_pulse,
  output logic              repeat_pulse,
  output logic              held,
  output logic [PCNT_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_TIME - 1);
  // With repeat disabled the terminal count is never compared. It is held
  // at 0 so that no negative value is ever cast.
  localparam logic [CNT_W-1:0] REP_TC =
    (REPEAT_TIME == 0) ? '0 : CNT_W'(REPEAT_TIME - 1);

  logic             rise;
  logic             fall;
  logic             press_ev;
  btn_state_e       state;
  logic [CNT_W-1:0] timer;

  edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (sw_db),
    .rise  (rise),
    .fall  (fall)
  );

  // In HELD/LONG the history bit is always 1, so a rise can only occur in IDLE.
  assign press_ev = (state == S_IDLE) && rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rise) begin
            press_pulse <= 1'b1;
            held        <= 1'b1;
            timer       <= '0;
            state       <= S_HELD;
          end
        end
        S_HELD: begin
          // fall wins over long on the same edge
          if (fall) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            timer         <= '0;
            state         <= S_IDLE;
          end else if (timer == LONG_TC) begin
            long_pulse <= 1'b1;
            timer      <= '0;
            state      <= S_LONG;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_LONG: begin
          if (fall) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            timer         <= '0;
            state         <= S_IDLE;
          end else if (REPEAT_TIME != 0) begin
            if (timer == REP_TC) begin
              repeat_pulse <= 1'b1;
              timer        <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          held  <= 1'b0;
          timer <= '0;
        end
      endcase

      // clear takes effect first, so a coincident press leaves a count of 1
      if (clear_count)
        press_count <= press_ev ? PCNT_W'(1) : '0;
      else if (press_ev)
        press_count <= press_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_button_event_fsm.sv
module tb_button_event_fsm;
  import btn_pkg::*;

  localparam int LT  = 8;
  localparam int RT  = 4;
  localparam int CW  = min_cnt_w(8, 4);
  localparam int CW0 = min_cnt_w(8, 0);
  localparam int PW  = 3;

  // Event vectors: {press, release, long, repeat, held}
  localparam logic [4:0] EV_NONE  = 5'b00000;
  localparam logic [4:0] EV_HELD  = 5'b00001;
  localparam logic [4:0] EV_PRESS = 5'b10001;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_LONG  = 5'b00101;
  localparam logic [4:0] EV_REP   = 5'b00011;

  logic clk;
  logic reset;
  logic sw_db, clear_count;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;
  logic [PW-1:0] press_count;

  logic sw_db2, clear_count2;
  logic press_pulse2, release_pulse2, long_pulse2, repeat_pulse2, held2;
  logic [PW-1:0] press_count2;

  int n_checks = 0;
  int n_fail   = 0;

  button_event_fsm #(.LONG_TIME(LT), .REPEAT_TIME(RT), .CNT_W(CW), .PCNT_W(PW)) dut (
    .clk           (clk),
    .reset         (reset),
    .sw_db         (sw_db),
    .clear_count   (clear_count),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .press_count   (press_count)
  );

  button_event_fsm #(.LONG_TIME(LT), .REPEAT_TIME(0), .CNT_W(CW0), .PCNT_W(PW)) dut_norep (
    .clk           (clk),
    .reset         (reset),
    .sw_db         (sw_db2),
    .clear_count   (clear_count2),
    .press_pulse   (press_pulse2),
    .release_pulse (release_pulse2),
    .long_pulse    (long_pulse2),
    .repeat_pulse  (repeat_pulse2),
    .held          (held2),
    .press_count   (press_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, let one posedge sample them, check outputs at the next negedge.
  task automatic step(input logic sw, input logic clr, input logic [4:0] exp_ev, input string tag);
    sw_db       = sw;
    clear_count = clr;
    @(negedge clk);
    check(tag, {3'b000, press_pulse, release_pulse, long_pulse, repeat_pulse, held},
          {3'b000, exp_ev});
  endtask

  task automatic step2(input logic sw, input logic [4:0] exp_ev, input string tag);
    sw_db2 = sw;
    @(negedge clk);
    check(tag, {3'b000, press_pulse2, release_pulse2, long_pulse2, repeat_pulse2, held2},
          {3'b000, exp_ev});
  endtask

  initial begin
    logic [4:0] e;
    logic [PW-1:0] cnt_exp;
    int n_long2, n_rep2;

    reset = 1'b1; sw_db = 1'b0; clear_count = 1'b0;
    sw_db2 = 1'b0; clear_count2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_ev", {3'b000, press_pulse, release_pulse, long_pulse, repeat_pulse, held}, 8'h00);
    check("reset_cnt", {5'b0, press_count}, 8'h00);
    check("reset_ev2", {3'b000, press_pulse2, release_pulse2, long_pulse2, repeat_pulse2, held2}, 8'h00);
    reset = 1'b0;

    // 1: short press, 3 cycles high
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, EV_NONE, "t1_idle");
    step(1'b1, 1'b0, EV_PRESS, "t1_press");
    step(1'b1, 1'b0, EV_HELD, "t1_held");
    step(1'b1, 1'b0, EV_HELD, "t1_held");
    step(1'b0, 1'b0, EV_REL, "t1_release");
    step(1'b0, 1'b0, EV_NONE, "t1_after");
    check("t1_cnt", {5'b0, press_count}, 8'd1);

    // 2: hold 20 cycles -> long at +8, repeats at +12 and +16, fall beats third repeat
    step(1'b1, 1'b0, EV_PRESS, "t2_press");
    for (int i = 1; i < 20; i++) begin
      e = (i == 8) ? EV_LONG : ((i == 12 || i == 16) ? EV_REP : EV_HELD);
      step(1'b1, 1'b0, e, "t2_hold");
    end
    step(1'b0, 1'b0, EV_REL, "t2_release");
    step(1'b0, 1'b0, EV_NONE, "t2_after");
    check("t2_cnt", {5'b0, press_count}, 8'd2);

    // 3: fall on the edge where timer == LONG_TIME-1
    step(1'b1, 1'b0, EV_PRESS, "t3_press");
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, EV_HELD, "t3_hold");
    step(1'b0, 1'b0, EV_REL, "t3_release_only");
    step(1'b0, 1'b0, EV_NONE, "t3_after");
    check("t3_cnt", {5'b0, press_count}, 8'd3);

    // 4: clear, nine presses wrap 1..7,0,1, then clear with the tenth press -> 1
    step(1'b0, 1'b1, EV_NONE, "t4_clear");
    check("t4_clear_cnt", {5'b0, press_count}, 8'd0);
    cnt_exp = '0;
    for (int k = 1; k <= 9; k++) begin
      cnt_exp = cnt_exp + 1'b1;
      step(1'b1, 1'b0, EV_PRESS, "t4_press");
      check("t4_cnt", {5'b0, press_count}, {5'b0, cnt_exp});
      step(1'b0, 1'b0, EV_REL, "t4_release");
    end
    check("t4_wrap_cnt", {5'b0, press_count}, 8'd1);
    step(1'b1, 1'b1, EV_PRESS, "t4_clr_press");
    check("t4_clr_press_cnt", {5'b0, press_count}, 8'd1);
    step(1'b0, 1'b0, EV_REL, "t4_release");

    // 5: reset while in LONG, then deassert with the button still down
    step(1'b1, 1'b0, EV_PRESS, "t5_press");
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, EV_HELD, "t5_hold");
    step(1'b1, 1'b0, EV_LONG, "t5_long");
    step(1'b1, 1'b0, EV_HELD, "t5_inlong");
    reset = 1'b1;
    #1;
    check("t5_rst_ev", {3'b000, press_pulse, release_pulse, long_pulse, repeat_pulse, held}, 8'h00);
    check("t5_rst_cnt", {5'b0, press_count}, 8'd0);
    @(negedge clk);
    check("t5_rst_norel", {3'b000, press_pulse, release_pulse, long_pulse, repeat_pulse, held}, 8'h00);
    reset = 1'b0;
    step(1'b1, 1'b0, EV_PRESS, "t5_repress");
    check("t5_cnt", {5'b0, press_count}, 8'd1);
    step(1'b1, 1'b0, EV_HELD, "t5_held");
    step(1'b0, 1'b0, EV_REL, "t5_release");

    // 6: repeat disabled, hold 30 cycles -> one long, no repeats
    n_long2 = 0;
    n_rep2  = 0;
    step2(1'b1, EV_PRESS, "t6_press");
    for (int i = 1; i < 30; i++) begin
      e = (i == 8) ? EV_LONG : EV_HELD;
      step2(1'b1, e, "t6_hold");
      if (long_pulse2)   n_long2++;
      if (repeat_pulse2) n_rep2++;
    end
    step2(1'b0, EV_REL, "t6_release");
    check("t6_long_count", 8'(n_long2), 8'd1);
    check("t6_repeat_count", 8'(n_rep2), 8'd0);
    check("t6_cnt", {5'b0, press_count2}, 8'd1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
